// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// the hardwired zero register and the default mult/div occupancy.
package hazard_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    LB_STALL2 = 1'b1
  } hazState_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned MD_LATENCY_DEFAULT = 4;

endpackage

// File: rtl/md_busy_counter.sv
// Down-counter tracking how long the HI/LO unit stays occupied after a
// mult/div issues; busy while the count is nonzero.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int unsigned LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= 4'(LATENCY - 1);
    end else if (count != '0) begin
      count <= count - 4'd1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch-operand and HI/LO interlocks,
// taken-branch flush and a saturating stall-cycle counter.
// Mult/div interlock is built only when HAZARD_MD_INTERLOCK_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rt,
  input  logic        id_branch,
  input  logic        id_md_start,
  input  logic        id_md_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        md_busy,
  output logic [15:0] stall_cnt
);

  hazState_t state;

  logic hitRs;
  logic hitRt;
  logic loadUse;
  logic aluBranch;
  logic loadBranch;
  logic mdStall;
  logic mdBusyRaw;
  logic stall;

  assign hitRs = (ex_rd != REG_ZERO) && (ex_rd == id_rs);
  assign hitRt = (ex_rd != REG_ZERO) && id_use_rt && (ex_rd == id_rt);

  assign loadUse    = ex_memread && (hitRs || hitRt);
  assign aluBranch  = id_branch && ex_regwrite && !ex_memread && (hitRs || hitRt);
  assign loadBranch = id_branch && ex_memread && (hitRs || hitRt);

`ifdef HAZARD_MD_INTERLOCK_EN
  logic mdLoad;

  assign mdStall = mdBusyRaw && (id_md_start || id_md_read);
  // Issue only when the ID instruction actually advances: not stalled, not squashed.
  assign mdLoad  = id_md_start && !stall && !ex_branch_taken;

  md_busy_counter #(
    .LATENCY (MD_LATENCY)
  ) u_mdBusyCounter (
    .clk  (clk),
    .rst  (rst),
    .load (mdLoad),
    .busy (mdBusyRaw)
  );
`else
  logic unusedMdInputs;

  assign unusedMdInputs = ^{id_md_start, id_md_read, MD_LATENCY[3:0]};
  assign mdStall        = 1'b0;
  assign mdBusyRaw      = 1'b0;
`endif

  assign stall = loadUse || aluBranch || loadBranch || mdStall || (state == LB_STALL2);

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst || ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign md_busy = mdBusyRaw && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else if (ex_branch_taken || state == LB_STALL2) begin
      state <= RUN;
    end else if (loadBranch) begin
      state <= LB_STALL2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_write && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned LAT = 4;
`ifdef HAZARD_MD_INTERLOCK_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_use_rt, id_branch, id_md_start, id_md_read;
  logic        ex_regwrite, ex_memread, ex_branch_taken;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, md_busy;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit lbOwed     = 1'b0;
  int mdRemain   = 0;
  int stallCount = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MD_LATENCY (LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rt       (id_use_rt),
    .id_branch       (id_branch),
    .id_md_start     (id_md_start),
    .id_md_read      (id_md_read),
    .ex_rd           (ex_rd),
    .ex_regwrite     (ex_regwrite),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .md_busy         (md_busy),
    .stall_cnt       (stall_cnt)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, check the outputs against the model, advance.
  task automatic cycle(input string name, input bit r,
                       input int rs, input int rt, input bit useRt, input bit br,
                       input bit mdS, input bit mdR,
                       input int rd, input bit rw, input bit mr, input bit tk);
    bit hit, loadBr, stall, accept;
    bit ePc, eIfw, eIff, eIdf, eBusy;
    rst = r; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rt = useRt; id_branch = br;
    id_md_start = mdS; id_md_read = mdR;
    ex_rd = 5'(rd); ex_regwrite = rw; ex_memread = mr; ex_branch_taken = tk;
    #4;
    hit    = (rd != 0) && (rd == rs || (useRt && rd == rt));
    loadBr = br && mr && hit;
    stall  = (mr && hit) || (br && rw && !mr && hit) || loadBr || lbOwed ||
             (MD_EN && mdRemain > 0 && (mdS || mdR));
    if (r || tk) begin
      ePc = 1; eIfw = 1; eIff = 1; eIdf = 1;
    end else if (stall) begin
      ePc = 0; eIfw = 0; eIff = 0; eIdf = 1;
    end else begin
      ePc = 1; eIfw = 1; eIff = 0; eIdf = 0;
    end
    eBusy = !r && MD_EN && mdRemain > 0;
    checkVal({name, ".pc_write"},   32'(pc_write),   32'(ePc));
    checkVal({name, ".ifid_write"}, 32'(ifid_write), 32'(eIfw));
    checkVal({name, ".ifid_flush"}, 32'(ifid_flush), 32'(eIff));
    checkVal({name, ".idex_flush"}, 32'(idex_flush), 32'(eIdf));
    checkVal({name, ".md_busy"},    32'(md_busy),    32'(eBusy));
    checkVal({name, ".stall_cnt"},  32'(stall_cnt),  32'(stallCount));
    accept = MD_EN && mdS && !stall && !tk;
    @(posedge clk);
    if (r) begin
      lbOwed = 0; mdRemain = 0; stallCount = 0;
    end else begin
      if (!ePc && stallCount < 65535) stallCount++;
      lbOwed = !tk && !lbOwed && loadBr;
      if (accept) mdRemain = LAT - 1;
      else if (mdRemain > 0) mdRemain--;
    end
    #1;
  endtask

  task automatic idle(input string name);
    cycle(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rt = 0; id_branch = 0; id_md_start = 0; id_md_read = 0;
    ex_regwrite = 0; ex_memread = 0; ex_branch_taken = 0;
    @(posedge clk); #1;

    cycle("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("post_reset");

    // load-use on rs
    cycle("load_use", 0, 5, 0, 0, 0, 0, 0, 5, 1, 1, 0);
    idle("load_use_after");

    // load-to-branch on rt: two bubbles
    cycle("ld_br1", 0, 1, 8, 1, 1, 0, 0, 8, 1, 1, 0);
    cycle("ld_br2", 0, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0);
    cycle("ld_br3", 0, 1, 8, 1, 1, 0, 0, 0, 0, 0, 0);

    // ALU result feeding a branch
    cycle("alu_br", 0, 9, 0, 0, 1, 0, 0, 9, 1, 0, 0);
    idle("alu_br_after");

    // zero register never hazards
    cycle("zero_reg", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

    // taken branch overrides a load-use stall
    cycle("flush_prio", 0, 5, 0, 0, 0, 0, 0, 5, 1, 1, 1);
    idle("flush_after");

    // mult/div occupancy
    cycle("md_c0", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle("md_c1");
    cycle("md_c2_read", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle("md_c3");
    cycle("md_c4_read", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // reset landing in the second load-to-branch bubble with mult/div in flight
    cycle("rm_c0", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cycle("rm_c1", 0, 3, 0, 0, 1, 0, 0, 3, 1, 1, 0);
    cycle("rm_c2_rst", 1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle("rm_after");
    idle("rm_after2");

    for (int i = 0; i < 2000; i++) begin
      cycle("rand",
            ($urandom_range(0, 49) == 0),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MD_LATENCY, default 4, cycles a mult/div occupies the HI/LO unit (legal 2..15).
REQ-002 SHALL have port clk  in  1  single pipeline clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports id_use_rt, id_branch, id_md_start, id_md_read  in  1 each  ID instruction reads rt / is a branch / issues mult-div / reads HI-LO.
REQ-006 SHALL have ports ex_rd  in  5, ex_regwrite  in  1, ex_memread  in  1  destination and kind of the EX instruction.
REQ-007 SHALL have port ex_branch_taken  in  1  resolved taken branch in EX.
REQ-008 SHALL have outputs pc_write, ifid_write, ifid_flush, idex_flush, md_busy (1 each) and stall_cnt (16), the PC/IF-ID enables, bubble controls, unit-busy flag and stall-cycle counter.

Function
REQ-009 SHALL run FSM states RUN and LB_STALL2; LB_STALL2 is the second bubble of a load-to-branch hazard.
REQ-010 SHALL define hit_rs = (ex_rd != 0 && ex_rd == id_rs) and hit_rt = (ex_rd != 0 && id_use_rt && ex_rd == id_rt).
REQ-011 SHALL flag load-use when ex_memread && (hit_rs || hit_rt): 1-cycle stall, FSM stays RUN.
REQ-012 SHALL flag ALU-to-branch when id_branch && ex_regwrite && !ex_memread && (hit_rs || hit_rt): 1-cycle stall.
REQ-013 SHALL flag load-to-branch when id_branch && ex_memread && (hit_rs || hit_rt): stall this cycle, RUN -> LB_STALL2, stall one more cycle, then LB_STALL2 -> RUN unconditionally.
REQ-014 SHALL flag mult/div stall when md_busy && (id_md_start || id_md_read).
REQ-015 SHALL, in any stall cycle, drive pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0; otherwise pc_write=1, ifid_write=1, idex_flush=0.
REQ-016 SHALL, when ex_branch_taken=1, drive ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1, override every stall, and return the FSM to RUN next cycle.
REQ-017 SHALL load md_cnt with MD_LATENCY-1 and assert md_busy when id_md_start is accepted (no stall, no flush); md_busy is 1 while md_cnt != 0.
REQ-018 SHALL decrement md_cnt every cycle while nonzero, independent of stalls and flushes; md_busy falls the cycle md_cnt reaches 0.
REQ-019 SHALL increment stall_cnt on every cycle with pc_write=0, saturating at 16'hFFFF.
REQ-020 SHALL make all outputs combinational from registered state plus current inputs, with no combinational path from ex_branch_taken to md_cnt.

Reset
REQ-021 SHALL on rst=1 at a clock edge set FSM=RUN, md_cnt=0, stall_cnt=0, clearing any in-progress stall or mult/div.
REQ-022 SHALL while rst=1 drive pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, md_busy=0.

Configuration
REQ-023 SHALL, with HAZARD_MD_INTERLOCK_EN defined, implement REQ-014/017/018.
REQ-024 SHALL, without HAZARD_MD_INTERLOCK_EN, omit md_cnt, tie md_busy=0, ignore id_md_start and id_md_read; ports remain present.

Structure
REQ-025 SHALL take FSM state encoding (RUN=1'b0, LB_STALL2=1'b1), REG_ZERO=5'd0 and MD_LATENCY default from shared package hazard_pkg.
REQ-026 SHALL place the mult/div down-counter in sub-module md_busy_counter (load, count, busy).

Verification
REQ-027 SHALL cover load-use: ex_memread=1, ex_rd=5, id_rs=5 -> one cycle pc_write=0, idex_flush=1, stall_cnt 0->1, then pc_write=1.
REQ-028 SHALL cover load-to-branch: ex_memread=1, ex_rd=8, id_branch=1, id_rt=8, id_use_rt=1 -> two consecutive stall cycles, FSM RUN->LB_STALL2->RUN.
REQ-029 SHALL cover zero register: ex_memread=1, ex_rd=0, id_rs=0 -> no stall.
REQ-030 SHALL cover flush priority: load-use hazard plus ex_branch_taken=1 same cycle -> pc_write=1, ifid_flush=1, idex_flush=1, stall_cnt unchanged.
REQ-031 SHALL cover mult/div: MD_LATENCY=4, accept id_md_start at cycle 0 -> md_busy=1 cycles 1-3; id_md_read at cycle 2 stalls; id_md_read at cycle 4 does not.
REQ-032 SHALL cover reset mid-operation: rst=1 during LB_STALL2 with md_cnt=2 -> next cycle FSM=RUN, md_busy=0, stall_cnt=0.
